// File: rtl/cart_mem_arbiter_pkg.sv
// Shared cartridge types: mapper kinds, memory arbiter state and data/address constants.
package cart_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        MAPPER_NONE,
        MAPPER_ASCII8,
        MAPPER_ASCII16,
        MAPPER_KONAMI,
        MAPPER_KONAMI_SCC
    } mapper_typ_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } cart_arb_state_t;

    localparam logic [7:0]  CART_DATA_UNMAPPED = 8'hFF;
    localparam int unsigned CART_ADDR_W        = 25;

endpackage

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge memory port between the ROM-image loader and two slot mappers,
// with round-robin between slots, local answers for unmapped reads and a hang watchdog.
module cart_mem_arbiter
    import cart_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dl_req,
    input  logic [CART_ADDR_W-1:0] dl_addr,
    input  logic [7:0]             dl_data,
    output logic                   dl_ack,
    input  logic [1:0]             rd_req,
    input  logic [CART_ADDR_W-1:0] rd_addr0,
    input  logic [CART_ADDR_W-1:0] rd_addr1,
    input  logic [1:0]             rd_unmaped,
    output logic [7:0]             rd_data,
    output logic [1:0]             rd_ack,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [CART_ADDR_W-1:0] mem_addr,
    output logic [7:0]             mem_din,
    input  logic [7:0]             mem_dout,
    input  logic                   mem_ready,
    output logic                   timeout_err
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    cart_arb_state_t        state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic                   slot_q, slot_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [CART_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]             mem_din_q, mem_din_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   dl_ack_q, dl_ack_d;
    logic [1:0]             rd_ack_q, rd_ack_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   pick;

    // Slot to serve: the one not served last when both ask, otherwise whichever asks.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        rd_data_d     = rd_data_q;
        dl_ack_d      = 1'b0;
        rd_ack_d      = 2'b00;
        timeout_err_d = timeout_err_q;
        pick          = rr_pick(rd_req, rr_last_q);

        case (state_q)
            IDLE: begin
                if (dl_req) begin
                    mem_addr_d = dl_addr;
                    mem_din_d  = dl_data;
                    mem_we_d   = 1'b1;
                    mem_req_d  = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = WAIT;
                end else if (rd_req != 2'b00) begin
                    rr_last_d = pick;
                    slot_d    = pick;
                    if (rd_unmaped[pick]) begin
                        rd_data_d      = CART_DATA_UNMAPPED;
                        rd_ack_d[pick] = 1'b1;
                        state_d        = DONE;
                    end else begin
                        mem_addr_d = pick ? rd_addr1 : rd_addr0;
                        mem_we_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        cnt_d      = 16'd0;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                // A ready in the final watchdog cycle still counts as a completed access.
                if (mem_ready || cnt_q == TimeoutLast) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_ready) begin
                        timeout_err_d = 1'b1;
                    end
                    if (mem_we_q) begin
                        dl_ack_d = 1'b1;
                    end else begin
                        rd_data_d        = mem_ready ? mem_dout : CART_DATA_UNMAPPED;
                        rd_ack_d[slot_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            slot_q        <= 1'b0;
            cnt_q         <= 16'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= 8'd0;
            rd_data_q     <= CART_DATA_UNMAPPED;
            dl_ack_q      <= 1'b0;
            rd_ack_q      <= 2'b00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            rd_data_q     <= rd_data_d;
            dl_ack_q      <= dl_ack_d;
            rd_ack_q      <= rd_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign rd_data     = rd_data_q;
    assign dl_ack      = dl_ack_q;
    assign rd_ack      = rd_ack_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of the arbiter.
module tb_cart_mem_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dl_req;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_ack;
    logic [1:0]  rd_req;
    logic [24:0] rd_addr0;
    logic [24:0] rd_addr1;
    logic [1:0]  rd_unmaped;
    logic [7:0]  rd_data;
    logic [1:0]  rd_ack;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_ready;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Model: what the outputs must show in the current cycle.
    logic        m_req = 1'b0;
    logic        m_we = 1'b0;
    logic [24:0] m_addr = '0;
    logic [7:0]  m_din = 8'd0;
    logic [7:0]  m_rd_data = 8'hFF;
    logic        m_terr = 1'b0;
    logic        m_rr_last = 1'b1;
    logic        m_dl_ack = 1'b0;
    logic [1:0]  m_rd_ack = 2'b00;
    logic        m_slot = 1'b0;
    int          m_waited = 0;

    logic [1:0]  ra;
    logic        da;
    logic [2:0]  drop;

    cart_mem_arbiter #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dl_req     (dl_req),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_ack     (dl_ack),
        .rd_req     (rd_req),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_unmaped (rd_unmaped),
        .rd_data    (rd_data),
        .rd_ack     (rd_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_ready  (mem_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        chk("mem_addr", {7'd0, mem_addr}, {7'd0, m_addr});
        chk("mem_din", {24'd0, mem_din}, {24'd0, m_din});
        chk("dl_ack", {31'd0, dl_ack}, {31'd0, m_dl_ack});
        chk("rd_ack", {30'd0, rd_ack}, {30'd0, m_rd_ack});
        chk("rd_data", {24'd0, rd_data}, {24'd0, m_rd_data});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    endtask

    // Advance the model by one cycle using this cycle's inputs.
    task automatic model_step();
        logic acking;
        logic s;
        acking = m_dl_ack || (m_rd_ack != 2'b00);
        m_dl_ack = 1'b0;
        m_rd_ack = 2'b00;
        if (reset) begin
            m_req = 1'b0;
            m_we = 1'b0;
            m_addr = '0;
            m_din = 8'd0;
            m_rd_data = 8'hFF;
            m_terr = 1'b0;
            m_rr_last = 1'b1;
            m_waited = 0;
        end else if (acking) begin
            // requests are not looked at while an ack is showing
        end else if (m_req) begin
            if (mem_ready || (m_waited + 1 == int'(TIMEOUT))) begin
                m_req = 1'b0;
                if (!mem_ready) m_terr = 1'b1;
                if (m_we) begin
                    m_dl_ack = 1'b1;
                end else begin
                    m_rd_data = mem_ready ? mem_dout : 8'hFF;
                    m_rd_ack = m_slot ? 2'b10 : 2'b01;
                end
            end else begin
                m_waited++;
            end
        end else if (dl_req) begin
            m_req = 1'b1;
            m_we = 1'b1;
            m_addr = dl_addr;
            m_din = dl_data;
            m_waited = 0;
        end else if (rd_req != 2'b00) begin
            s = (rd_req == 2'b11) ? !m_rr_last : rd_req[1];
            m_rr_last = s;
            m_slot = s;
            if (rd_unmaped[s]) begin
                m_rd_data = 8'hFF;
                m_rd_ack = s ? 2'b10 : 2'b01;
            end else begin
                m_req = 1'b1;
                m_we = 1'b0;
                m_addr = s ? rd_addr1 : rd_addr0;
                m_waited = 0;
            end
        end
    endtask

    // Close the current cycle: check and step the model, then move to the next drive point.
    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Memory answers in the first cycle it sees mem_req; returns the first ack observed.
    task automatic run_until_ack(input logic [7:0] dout, output logic [1:0] ack_r,
                                 output logic ack_d);
        logic got;
        got = 1'b0;
        ack_r = 2'b00;
        ack_d = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            mem_ready = mem_req;
            mem_dout = dout;
            tick();
            if (rd_ack != 2'b00 || dl_ack) begin
                got = 1'b1;
                ack_r = rd_ack;
                ack_d = dl_ack;
            end
        end
        mem_ready = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        dl_req = 1'b0;
        dl_addr = '0;
        dl_data = 8'd0;
        rd_req = 2'b00;
        rd_addr0 = '0;
        rd_addr1 = '0;
        rd_unmaped = 2'b00;
        mem_dout = 8'd0;
        mem_ready = 1'b0;
        drop = 3'b000;

        tick();
        reset = 1'b0;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'hFF);
        chk("rst_acks", {29'd0, dl_ack, rd_ack}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);

        // Single mapped read, memory answers two cycles after mem_req
        rd_req = 2'b01;
        rd_addr0 = 25'h0004000;
        tick();
        chk("rd1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rd1_addr", {7'd0, mem_addr}, 32'h0004000);
        chk("rd1_we", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_dout = 8'hA5;
        tick();
        mem_ready = 1'b0;
        chk("rd1_ack", {30'd0, rd_ack}, 32'd1);
        chk("rd1_data", {24'd0, rd_data}, 32'hA5);
        tick();
        rd_req = 2'b00;
        tick();

        // Unmapped read on slot 1 answers locally in one cycle
        rd_req = 2'b10;
        rd_unmaped = 2'b10;
        rd_addr1 = 25'h1ABCDE;
        tick();
        chk("unm_ack", {30'd0, rd_ack}, 32'd2);
        chk("unm_data", {24'd0, rd_data}, 32'hFF);
        chk("unm_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        rd_req = 2'b00;
        rd_unmaped = 2'b00;
        tick();

        // Contention: slots alternate, loader overtakes pending reads
        rd_addr0 = 25'h00000A0;
        rd_addr1 = 25'h00000A1;
        rd_req = 2'b11;
        run_until_ack(8'h11, ra, da);
        chk("cont_g1", {30'd0, ra}, 32'd1);
        chk("cont_d1", {24'd0, rd_data}, 32'h11);
        tick();
        rd_req = 2'b10;
        tick();
        rd_req = 2'b11;
        run_until_ack(8'h22, ra, da);
        chk("cont_g2", {30'd0, ra}, 32'd2);
        chk("cont_d2", {24'd0, rd_data}, 32'h22);
        tick();
        rd_req = 2'b01;
        tick();
        rd_req = 2'b11;
        run_until_ack(8'h33, ra, da);
        chk("cont_g3", {30'd0, ra}, 32'd1);
        tick();
        rd_req = 2'b10;
        dl_req = 1'b1;
        dl_addr = 25'h0ABCDEF;
        dl_data = 8'h5A;
        tick();
        rd_req = 2'b11;
        chk("dl_mem_req", {31'd0, mem_req}, 32'd1);
        chk("dl_we", {31'd0, mem_we}, 32'd1);
        chk("dl_din", {24'd0, mem_din}, 32'h5A);
        chk("dl_addr", {7'd0, mem_addr}, 32'h0ABCDEF);
        run_until_ack(8'h99, ra, da);
        chk("dl_ack", {31'd0, da}, 32'd1);
        chk("dl_rd_data_held", {24'd0, rd_data}, 32'h33);
        tick();
        dl_req = 1'b0;
        tick();
        chk("cont_after_dl", {7'd0, mem_addr}, 32'h00000A1);
        run_until_ack(8'h44, ra, da);
        chk("cont_g4", {30'd0, ra}, 32'd2);
        tick();
        rd_req = 2'b00;
        tick();

        // Ready arriving in the last watchdog cycle is a success
        rd_req = 2'b01;
        rd_addr0 = 25'h0123456;
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        mem_dout = 8'h3C;
        tick();
        mem_ready = 1'b0;
        chk("edge_ack", {30'd0, rd_ack}, 32'd1);
        chk("edge_data", {24'd0, rd_data}, 32'h3C);
        chk("edge_terr", {31'd0, timeout_err}, 32'd0);
        tick();
        rd_req = 2'b00;
        tick();

        // Watchdog abort
        rd_req = 2'b01;
        rd_addr0 = 25'h1FFFFFF;
        tick();
        chk("to_req_on", {31'd0, mem_req}, 32'd1);
        tick();
        tick();
        tick();
        chk("to_req_held", {31'd0, mem_req}, 32'd1);
        chk("to_terr_pre", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("to_req_off", {31'd0, mem_req}, 32'd0);
        chk("to_ack", {30'd0, rd_ack}, 32'd1);
        chk("to_data", {24'd0, rd_data}, 32'hFF);
        chk("to_terr", {31'd0, timeout_err}, 32'd1);
        tick();
        rd_req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset two cycles into WAIT
        rd_req = 2'b01;
        rd_addr0 = 25'h0000777;
        tick();
        tick();
        reset = 1'b1;
        rd_req = 2'b00;
        tick();
        reset = 1'b0;
        chk("rw_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rw_acks", {29'd0, dl_ack, rd_ack}, 32'd0);
        chk("rw_terr", {31'd0, timeout_err}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rw_stray_ready", {29'd0, dl_ack, rd_ack}, 32'd0);
        tick();
        rd_req = 2'b11;
        rd_unmaped = 2'b11;
        tick();
        chk("rw_rr_slot0", {30'd0, rd_ack}, 32'd1);
        tick();
        rd_req = 2'b00;
        rd_unmaped = 2'b00;
        tick();

        // Random traffic with reactive requesters and memory
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (drop[2]) begin
                dl_req = 1'b0;
                drop[2] = 1'b0;
            end else if (dl_req) begin
                if (dl_ack) drop[2] = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                dl_req = 1'b1;
                dl_addr = 25'($urandom);
                dl_data = 8'($urandom);
            end
            for (int s = 0; s < 2; s++) begin
                if (drop[s]) begin
                    rd_req[s] = 1'b0;
                    drop[s] = 1'b0;
                end else if (rd_req[s]) begin
                    if (rd_ack[s]) drop[s] = 1'b1;
                end else if ($urandom_range(0, 3) == 0) begin
                    rd_req[s] = 1'b1;
                    rd_unmaped[s] = ($urandom_range(0, 3) == 0);
                    if (s == 0) rd_addr0 = 25'($urandom);
                    else rd_addr1 = 25'($urandom);
                end
            end
            mem_dout = 8'($urandom);
            mem_ready = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single cartridge ROM/RAM memory port (SDRAM-side request/ready interface) between three requesters:
  - the ioctl ROM-image loader (writes);
  - the slot-0 and slot-1 cartridge mapper reads (mapped 25-bit addresses plus unmapped flag from the bank mappers).
- Sequences each access through a small FSM and returns read data with a one-cycle ack.
- Unmapped reads are answered locally with 8'hFF.
- A hung memory port is caught by a watchdog.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without mem_ready before the access is aborted; legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dl_req  in  1  loader write request; level, held until dl_ack
- dl_addr  in  25  loader byte address
- dl_data  in  8  loader write data
- dl_ack  out  1  one-cycle pulse: loader write complete
- rd_req  in  2  per-slot read request; level, held until rd_ack[i]
- rd_addr0  in  25  slot-0 mapped address
- rd_addr1  in  25  slot-1 mapped address
- rd_unmaped  in  2  per-slot: address outside ROM/window, no memory access
- rd_data  out  8  read data; valid in the rd_ack cycle, held until the next ack
- rd_ack  out  2  one-cycle pulse per slot
- mem_req  out  1  memory request; level, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  25  memory address
- mem_din  out  8  write data to memory
- mem_dout  in  8  read data from memory; valid when mem_ready = 1
- mem_ready  in  1  one-cycle completion from the memory controller
- timeout_err  out  1  sticky; set on any watchdog abort

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state = IDLE.
  - mem_req, mem_we, dl_ack, rd_ack, timeout_err = 0.
  - mem_addr = 0, mem_din = 0.
  - rd_data = 8'hFF.
  - rr_last = 1, so slot 0 wins the first contested grant.
  - Reset mid-access drops mem_req at the next edge; no ack is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE, priority order:
  - dl_req: latch dl_addr/dl_data into mem_addr/mem_din, mem_we = 1, mem_req = 1, go to WAIT.
  - Otherwise, rd_req slots eligible; if both are set, grant the slot != rr_last. Then set rr_last = granted slot.
  - Granted slot with rd_unmaped = 1: rd_data = 8'hFF, go to DONE. mem_req stays 0.
  - Granted slot with rd_unmaped = 0: latch its address, mem_we = 0, mem_req = 1, go to WAIT.
  - A granted slot's address and unmaped flag are sampled only in the IDLE grant cycle.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_din are held stable. A 16-bit counter counts from 0.
  - On mem_ready: mem_req = 0; if this is a read, rd_data = mem_dout; go to DONE.
  - When the counter reaches TIMEOUT with no mem_ready: mem_req = 0, timeout_err = 1; a read returns rd_data = 8'hFF; go to DONE.
  - A mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
- DONE:
  - Pulse exactly one of dl_ack / rd_ack[g] for one cycle, then go to IDLE.
  - The requester must drop its req in the cycle after the ack. The arbiter does not sample requests during DONE.
- Latency:
  - request seen in IDLE at cycle 0 → mem_req high from cycle 1;
  - mem_ready at cycle N → ack at cycle N+1.
  - Minimum read latency is 2 cycles; an unmapped read completes in 1 cycle (ack at cycle 1).
- Throughput: back-to-back requests are spaced by at least one IDLE cycle. A loader held high starves the reads; this is intended, since the CPU is halted during loading.
- The round-robin pointer changes only on slot grants, never on loader grants.
- mem_ready received outside WAIT is ignored.

Decomposition:
- Shared package (alongside mapper_typ_t):
  - cart_arb_state_t enum {IDLE, WAIT, DONE};
  - constant CART_DATA_UNMAPPED = 8'hFF;
  - constant CART_ADDR_W = 25.
- No sub-module is needed. The 2-way round-robin pick is a local function.

Test Plan:
- Single read: rd_req = 01, rd_addr0 = 25'h0004000, mem_ready with mem_dout = 8'hA5 two cycles after mem_req → mem_addr = 25'h0004000, mem_we = 0, rd_ack = 01 one cycle after mem_ready, rd_data = 8'hA5.
- Unmapped read: rd_req = 10, rd_unmaped = 10 → rd_ack = 10 at cycle 1, rd_data = 8'hFF, mem_req never asserted.
- Contention: rd_req = 11 held, each slot re-requesting after its ack → grants alternate slot0, slot1, slot0; dl_req raised while both reads pend → loader granted at the next IDLE with mem_we = 1, mem_din = dl_data.
- Timeout: with TIMEOUT = 4, read issued and mem_ready never asserted → mem_req drops after 4 WAIT cycles, rd_ack pulses, rd_data = 8'hFF, timeout_err = 1 and stays 1 until reset.
- Reset mid-WAIT: assert reset two cycles into WAIT → mem_req = 0 next edge, no ack; a later mem_ready is ignored; rr_last = 1, so the next contested grant goes to slot 0.
